jpeg_stage_sequencer: RTL and testbench

- Parametrised top-level sequencer for the JPEG encoder pipeline.
- Drives NUM_STAGES processing blocks (RGB2YCBCR, DCT, QUAN, HUFF, …) one at a time with a one-hot enable/done handshake.
- Repeats the stage chain for NUM_BLOCKS 8x8 blocks per frame, then raises a frame-complete pulse.
- Adds what the fixed two-stage controller lacks: a real DONE state, per-stage watchdog timeout, abort, and progress/status outputs.

---
 rtl/jpeg_ctrl_pkg.sv | 24 ++
 rtl/stage_watchdog.sv | 35 +++
 rtl/jpeg_stage_sequencer.sv | 107 ++++++++++
 tb/tb_jpeg_stage_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_ctrl_pkg.sv
// Shared encodings for the JPEG encoder control path: sequencer states,
// pipeline stage indices and the default frame size.
package jpeg_ctrl_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_RUN  = RUN,
    S_DONE = DONE,
    S_ERR  = ERR
  } state_t;

  localparam int STG_RGB2YCBCR = 0;
  localparam int STG_DCT       = 1;
  localparam int STG_QUAN      = 2;
  localparam int STG_HUFF      = 3;

  localparam int DEFAULT_NUM_BLOCKS = 64;

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog: counts cycles a stage stays enabled without finishing
// and flags the terminal count. TIMEOUT=0 removes the counter entirely.
module stage_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, clr, inc};
    assign expired = 1'b0;
  end else begin : g_on
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Holds at the terminal count; the sequencer leaves RUN on that cycle anyway.
    always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
        cnt <= '0;
      end else if (inc && cnt != TERM) begin
        cnt <= cnt + CW'(1);
      end
    end

    assign expired = (cnt == TERM);
  end

endmodule

// File: rtl/jpeg_stage_sequencer.sv
// Frame sequencer for the JPEG encoder: walks NUM_STAGES blocks with a one-hot
// enable/done handshake for each of NUM_BLOCKS 8x8 blocks, with watchdog and abort.
module jpeg_stage_sequencer
  import jpeg_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int NUM_BLOCKS = DEFAULT_NUM_BLOCKS,
  parameter int TIMEOUT    = 4096,
  parameter int BLK_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1,
  parameter int STG_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [STG_W-1:0]      cur_stage,
  output logic [BLK_W-1:0]      blk_idx,
  output logic                  busy,
  output logic                  valid,
  output logic                  error
);

  localparam logic [STG_W-1:0]      LAST_STG = STG_W'(NUM_STAGES - 1);
  localparam logic [BLK_W-1:0]      LAST_BLK = BLK_W'(NUM_BLOCKS - 1);
  localparam logic [NUM_STAGES-1:0] FIRST_EN = NUM_STAGES'(1);

  state_t state;
  logic   done_k;
  logic   expired;
  logic   wd_clr;
  logic   wd_inc;

  // stage_en is one-hot on the active stage in RUN and zero elsewhere, so the
  // mask picks out stage_done[k] and ignores every other done bit.
  assign done_k = |(stage_done & stage_en);
  assign wd_clr = (state != S_RUN) || done_k;
  assign wd_inc = (state == S_RUN) && !done_k;

  stage_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .inc    (wd_inc),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      state     <= S_IDLE;
      stage_en  <= '0;
      cur_stage <= '0;
      blk_idx   <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      error     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_ERR: begin
          if (start) begin
            state     <= S_RUN;
            stage_en  <= FIRST_EN;
            cur_stage <= '0;
            blk_idx   <= '0;
            busy      <= 1'b1;
            error     <= 1'b0;
          end
        end
        S_RUN: begin
          if (done_k) begin
            if (cur_stage != LAST_STG) begin
              cur_stage <= cur_stage + STG_W'(1);
              stage_en  <= stage_en << 1;
            end else if (blk_idx != LAST_BLK) begin
              cur_stage <= '0;
              blk_idx   <= blk_idx + BLK_W'(1);
              stage_en  <= FIRST_EN;
            end else begin
              // blk_idx stays on the last block through the DONE cycle.
              state     <= S_DONE;
              cur_stage <= '0;
              stage_en  <= '0;
              busy      <= 1'b0;
              valid     <= 1'b1;
            end
          end else if (expired) begin
            // cur_stage and blk_idx are left pointing at the stalled stage.
            state    <= S_ERR;
            stage_en <= '0;
            busy     <= 1'b0;
            error    <= 1'b1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          valid   <= 1'b0;
          blk_idx <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_stage_sequencer.sv
// Directed bench for jpeg_stage_sequencer: a 4-stage/2-block/TIMEOUT=16 instance
// and a 1-stage/1-block instance with the watchdog disabled.
module tb_jpeg_stage_sequencer;

  typedef struct packed {
    logic [3:0] en;
    logic [1:0] cur;
    logic       blk;
    logic       v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, abort_a;
  logic [3:0] done_a, en_a;
  logic [1:0] cur_a;
  logic [0:0] blk_a;
  logic       busy_a, valid_a, error_a;

  logic       start_b, abort_b;
  logic [0:0] done_b, en_b, cur_b, blk_b;
  logic       busy_b, valid_b, error_b;

  int   vectors = 0;
  int   miscompares = 0;
  int   va, nv, n;
  exp_t q[$];

  jpeg_stage_sequencer #(
    .NUM_STAGES(4),
    .NUM_BLOCKS(2),
    .TIMEOUT   (16)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_a),
    .abort     (abort_a),
    .stage_done(done_a),
    .stage_en  (en_a),
    .cur_stage (cur_a),
    .blk_idx   (blk_a),
    .busy      (busy_a),
    .valid     (valid_a),
    .error     (error_a)
  );

  jpeg_stage_sequencer #(
    .NUM_STAGES(1),
    .NUM_BLOCKS(1),
    .TIMEOUT   (0)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .abort     (abort_b),
    .stage_done(done_b),
    .stage_en  (en_b),
    .cur_stage (cur_b),
    .blk_idx   (blk_b),
    .busy      (busy_b),
    .valid     (valid_b),
    .error     (error_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected stage entries for one full frame, then the frame-complete record.
  task automatic push_frame();
    exp_t e;
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < 4; s++) begin
        e.en  = 4'(1 << s);
        e.cur = 2'(s);
        e.blk = 1'(b);
        e.v   = 1'b0;
        q.push_back(e);
      end
    end
    e.en  = 4'b0000;
    e.cur = 2'd0;
    e.blk = 1'b1;
    e.v   = 1'b1;
    q.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    chk("sb_nonempty", 32'(q.size() != 0), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("sb_en", en_a, e.en);
      chk("sb_cur", cur_a, e.cur);
      chk("sb_blk", blk_a, e.blk);
      chk("sb_valid", valid_a, e.v);
      chk("sb_busy", busy_a, !e.v);
    end
  endtask

  // Responder for dut_a: answers each stage enable with done after 'delay'
  // cycles. mode 1 aborts at block 1/stage 2, mode 2 resets at block 1/stage 3.
  // ds drives start during the DONE cycle.
  task automatic run_a(input int delay, input int budget, input int mode, input bit ds,
                       output int valid_at, output int nvalid);
    logic [3:0] prev;
    int         age;
    bit         cut;
    prev = '0;
    age = 0;
    cut = 1'b0;
    valid_at = -1;
    nvalid = 0;
    for (int i = 1; i <= budget; i++) begin
      step();
      start_a = 1'b0;
      done_a  = '0;
      if (cut) begin
        chk("cut_en", en_a, 0);
        chk("cut_cur", cur_a, 0);
        chk("cut_blk", blk_a, 0);
        chk("cut_busy", busy_a, 0);
        chk("cut_valid", valid_a, 0);
        chk("cut_error", error_a, 0);
        abort_a = 1'b0;
        rst_n   = 1'b1;
        break;
      end
      if (valid_at >= 0) begin
        chk("idle_valid", valid_a, 0);
        chk("idle_blk", blk_a, 0);
        chk("idle_en", en_a, 0);
        chk("idle_busy", busy_a, 0);
        if (!ds || i == valid_at + 2) break;
      end else if (valid_a) begin
        nvalid++;
        valid_at = i;
        pop_chk();
        if (ds) start_a = 1'b1;
      end else if (en_a != 4'b0000 && en_a != prev) begin
        pop_chk();
        chk("onehot", 32'($onehot(en_a)), 1);
        age = 0;
        if (mode == 1 && en_a == 4'b0100 && blk_a == 1'b1) begin
          abort_a = 1'b1;
          cut = 1'b1;
        end
        if (mode == 2 && en_a == 4'b1000 && blk_a == 1'b1) begin
          rst_n = 1'b0;
          cut = 1'b1;
        end
      end
      if (en_a != 4'b0000 && !cut) begin
        if (age == delay) done_a = en_a;
        age++;
      end
      prev = en_a;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0;
    abort_a = 1'b0;
    done_a = '0;
    start_b = 1'b0;
    abort_b = 1'b0;
    done_b = '0;
    step();
    step();
    chk("rst_en", en_a, 0);
    chk("rst_cur", cur_a, 0);
    chk("rst_blk", blk_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_error", error_a, 0);
    chk("rst_b_en", en_b, 0);
    chk("rst_b_valid", valid_b, 0);
    rst_n = 1'b1;
    step();

    // Nominal frame, done 3 cycles after each enable; start poked during DONE.
    q.delete();
    push_frame();
    start_a = 1'b1;
    run_a(3, 60, 0, 1'b1, va, nv);
    chk("nom_valid_cycle", va, 33);
    chk("nom_valid_count", nv, 1);
    chk("nom_error", error_a, 0);
    chk("nom_sb_drained", q.size(), 0);

    // Watchdog expiry on stage 1.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("to_en0", en_a, 4'b0001);
    done_a = 4'b0001;
    step();
    done_a = '0;
    n = 1;
    for (int j = 0; j < 40; j++) begin
      step();
      if (en_a == 4'b0010) n++;
      else break;
    end
    chk("to_en_cycles", n, 16);
    chk("to_error", error_a, 1);
    chk("to_cur", cur_a, 1);
    chk("to_blk", blk_a, 0);
    chk("to_busy", busy_a, 0);
    chk("to_en", en_a, 0);
    repeat (3) step();
    chk("to_sticky", error_a, 1);
    chk("to_cur_frozen", cur_a, 1);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("err_restart_en", en_a, 4'b0001);
    chk("err_restart_error", error_a, 0);
    chk("err_restart_cur", cur_a, 0);
    chk("err_restart_busy", busy_a, 1);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk("abort_run_en", en_a, 0);

    // Stray done bits, then the real done on the expiry cycle.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    done_a = 4'b1110;
    for (int j = 1; j <= 15; j++) begin
      step();
      chk("stray_hold", en_a, 4'b0001);
    end
    done_a = 4'b1111;
    step();
    done_a = '0;
    chk("race_en", en_a, 4'b0010);
    chk("race_cur", cur_a, 1);
    chk("race_error", error_a, 0);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;

    // Abort at block 1, stage 2, then a clean frame.
    q.delete();
    push_frame();
    start_a = 1'b1;
    run_a(1, 60, 1, 1'b0, va, nv);
    chk("abort_no_valid", nv, 0);
    q.delete();
    push_frame();
    start_a = 1'b1;
    run_a(1, 60, 0, 1'b0, va, nv);
    chk("after_abort_valid_cycle", va, 17);
    chk("after_abort_valid_count", nv, 1);

    // Reset at block 1, stage 3.
    q.delete();
    push_frame();
    start_a = 1'b1;
    run_a(2, 80, 2, 1'b0, va, nv);
    chk("rst_mid_no_valid", nv, 0);
    q.delete();
    step();
    chk("rst_mid_idle_valid", valid_a, 0);

    // abort together with start in IDLE.
    abort_a = 1'b1;
    start_a = 1'b1;
    step();
    abort_a = 1'b0;
    start_a = 1'b0;
    chk("abort_start_en", en_a, 0);
    chk("abort_start_busy", busy_a, 0);
    step();
    chk("abort_start_en2", en_a, 0);

    // Single stage, single block, watchdog off.
    start_b = 1'b1;
    done_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("b_en", en_b, 1);
    chk("b_busy", busy_b, 1);
    step();
    chk("b_valid", valid_b, 1);
    chk("b_done_en", en_b, 0);
    chk("b_done_blk", blk_b, 0);
    step();
    chk("b_valid_pulse", valid_b, 0);
    done_b = 1'b0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    repeat (10000) step();
    chk("b_no_timeout_error", error_b, 0);
    chk("b_no_timeout_en", en_b, 1);
    chk("b_no_timeout_busy", busy_b, 1);
    abort_b = 1'b1;
    step();
    abort_b = 1'b0;
    chk("b_abort_en", en_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
